multiport_register_file: RTL and testbench
==========================================

// Module: multiport_register_file
//
// PURPOSE
//  Parametrised general-purpose register file for the 19-bit CPU datapath.
//  - Generalises the fixed A-C register block to NUM_REGS registers with one write port and NUM_RD_PORTS registered read ports.
//  - Adds a per-register busy scoreboard so the control unit can stall reads of registers with a pending result.
//  - Sits between the decode/control stage (addresses, enables) and the ALU/data bus (read/write data).
//
// PARAMETERS
//  WORD_SIZE     19                     data width of each register
//  NUM_REGS      4                      number of registers (>= 2)
//  NUM_RD_PORTS  2                      number of independent read ports (>= 1)
//  ADDR_W        $clog2(NUM_REGS)       register address width (derived, do not override)
//
// PORTS
//  CLK        in   1                        clock, all state updates on posedge
//  RST_N      in   1                        asynchronous reset, active-low
//  WR_EN      in   1                        write strobe
//  WR_ADDR    in   ADDR_W                   write register index
//  WR_DATA    in   WORD_SIZE                write data
//  BUSY_SET   in   1                        mark BUSY_ADDR as having a pending producer
//  BUSY_ADDR  in   ADDR_W                   register index to mark busy
//  RD_EN      in   NUM_RD_PORTS             per-port read request
//  RD_ADDR    in   NUM_RD_PORTS*ADDR_W      per-port read index; port p = bits [p*ADDR_W +: ADDR_W]
//  RD_DATA    out  NUM_RD_PORTS*WORD_SIZE   per-port read data; port p = bits [p*WORD_SIZE +: WORD_SIZE]
//  RD_VALID   out  NUM_RD_PORTS             one-cycle pulse: RD_DATA[p] is valid
//  RD_STALL   out  NUM_RD_PORTS             one-cycle pulse: request p was refused (register busy)
//  BUSY       out  NUM_REGS                 scoreboard state, bit i = register i busy
//  ADDR_ERR   out  1                        one-cycle pulse: an enabled access used index >= NUM_REGS
//
// BEHAVIOUR
//  Reset
//  - RST_N low: all registers, BUSY, RD_DATA, RD_VALID, RD_STALL and ADDR_ERR are cleared to 0 immediately.
//  - Reset is asynchronous and wins over every other event. Requests in flight are dropped; no RD_VALID follows.
//
//  Write
//  - WR_EN=1 at the edge: reg[WR_ADDR] <= WR_DATA and BUSY[WR_ADDR] <= 0.
//  - Written data is visible to reads issued on the next cycle.
//
//  Scoreboard
//  - BUSY_SET=1 at the edge: BUSY[BUSY_ADDR] <= 1.
//  - If BUSY_SET and WR_EN target the same index in the same cycle, set wins: the register is written and BUSY=1.
//
//  Read (latency 1, per port p, all ports independent)
//  - RD_EN[p]=1 with index in range and BUSY=0: next cycle RD_DATA[p] = register value, RD_VALID[p]=1.
//  - RD_EN[p]=1 with BUSY=1: next cycle RD_STALL[p]=1, RD_VALID[p]=0, RD_DATA[p] holds its previous value.
//  - RD_EN[p]=0: RD_VALID[p]=0, RD_STALL[p]=0, RD_DATA[p] holds.
//  - Several ports may read the same register in the same cycle; each gets the same value.
//
//  Same-cycle read/write, same index
//  - The read returns the OLD value.
//  - If the register was busy, the read stalls.
//  - (WRITE_BYPASS_EN changes this; see CONFIGURATION.)
//
//  Out-of-range index (possible only when NUM_REGS is not a power of two)
//  - Write: ignored.
//  - Read: next cycle RD_VALID[p]=1 with RD_DATA[p]=0.
//  - BUSY_SET: ignored.
//  - Each case raises ADDR_ERR for one cycle.
//
// CONFIGURATION
//  WRITE_BYPASS_EN
//  - Defined: a read whose index equals WR_ADDR while WR_EN=1 returns WR_DATA next cycle with RD_VALID=1.
//    The pending write clears busy for that read, so it does not stall, even if BUSY was 1.
//  - Undefined: no forwarding; old value is returned, or a stall if busy.
//
// TESTING
//  1. Reset: drive RST_N low mid-read -> RD_VALID=0, all BUSY=0, all registers read back 0x00000.
//  2. Write 0x7FFFF to r2, then read r2 on both ports next cycle -> both ports RD_VALID=1, RD_DATA=0x7FFFF one cycle later.
//  3. BUSY_SET r1, then read r1 on port0 -> RD_STALL[0]=1.
//     Then write 0x00123 to r1 -> BUSY[1]=0; re-read r1 -> data 0x00123.
//  4. Same cycle: WR_EN r3=0x55555 and port1 reads r3 (old value 0x0000A).
//     Without WRITE_BYPASS_EN -> 0x0000A. With it -> 0x55555.
//  5. Same cycle: BUSY_SET r0 and WR_EN r0=0x00001 -> r0=0x00001, BUSY[0]=1.
//  6. NUM_REGS=3: write index 3 -> ADDR_ERR pulses, r0..r2 unchanged.
//     Read index 3 -> RD_VALID=1, RD_DATA=0, ADDR_ERR pulses.

Source files
------------

// File: rtl/multiport_register_file.sv
// Parametrised register file: one write port, NUM_RD_PORTS registered read ports, per-register busy scoreboard.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data to matching reads.
module multiport_register_file #(
  parameter  int WORD_SIZE    = 19,
  parameter  int NUM_REGS     = 4,
  parameter  int NUM_RD_PORTS = 2,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              WR_EN,
  input  logic [ADDR_W-1:0]                 WR_ADDR,
  input  logic [WORD_SIZE-1:0]              WR_DATA,
  input  logic                              BUSY_SET,
  input  logic [ADDR_W-1:0]                 BUSY_ADDR,
  input  logic [NUM_RD_PORTS-1:0]           RD_EN,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0]    RD_ADDR,
  output logic [NUM_RD_PORTS*WORD_SIZE-1:0] RD_DATA,
  output logic [NUM_RD_PORTS-1:0]           RD_VALID,
  output logic [NUM_RD_PORTS-1:0]           RD_STALL,
  output logic [NUM_REGS-1:0]               BUSY,
  output logic                              ADDR_ERR
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [WORD_SIZE-1:0]              r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]               r_busy;
  logic [NUM_RD_PORTS*WORD_SIZE-1:0] r_rd_data;
  logic [NUM_RD_PORTS-1:0]           r_rd_valid;
  logic [NUM_RD_PORTS-1:0]           r_rd_stall;
  logic                              r_addr_err;

  logic [ADDR_W-1:0]       w_rd_idx [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] w_rd_oor;
  logic [NUM_RD_PORTS-1:0] w_fwd;
  logic                    w_addr_err;
  logic                    w_wr_ok;
  logic                    w_bs_ok;

  // Indices only fall out of range when NUM_REGS is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  assign w_wr_ok = WR_EN && in_range(WR_ADDR);
  assign w_bs_ok = BUSY_SET && in_range(BUSY_ADDR);

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_addr_err = (WR_EN && !in_range(WR_ADDR)) || (BUSY_SET && !in_range(BUSY_ADDR));
    w_rd_oor   = '0;
    w_fwd      = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      w_rd_idx[p] = RD_ADDR[p*ADDR_W +: ADDR_W];
      w_rd_oor[p] = !in_range(w_rd_idx[p]);
`ifdef WRITE_BYPASS_EN
      w_fwd[p]    = w_wr_ok && (WR_ADDR == w_rd_idx[p]);
`else
      w_fwd[p]    = 1'b0;
`endif
      if (RD_EN[p] && w_rd_oor[p]) w_addr_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the register array is reset explicitly because reads after reset must return zero.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_rd_stall <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_valid <= '0;
      r_rd_stall <= '0;
      r_addr_err <= w_addr_err;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (RD_EN[p]) begin
          if (w_rd_oor[p]) begin
            r_rd_valid[p]                         <= 1'b1;
            r_rd_data[p*WORD_SIZE +: WORD_SIZE]   <= '0;
          end else if (w_fwd[p]) begin
            r_rd_valid[p]                         <= 1'b1;
            r_rd_data[p*WORD_SIZE +: WORD_SIZE]   <= WR_DATA;
          end else if (r_busy[w_rd_idx[p]]) begin
            r_rd_stall[p]                         <= 1'b1;
          end else begin
            r_rd_valid[p]                         <= 1'b1;
            r_rd_data[p*WORD_SIZE +: WORD_SIZE]   <= r_regs[w_rd_idx[p]];
          end
        end
      end
      if (w_wr_ok) begin
        r_regs[WR_ADDR] <= WR_DATA;
        r_busy[WR_ADDR] <= 1'b0;
      end
      // Placed after the write so a same-index set overrides the write's clear.
      if (w_bs_ok) r_busy[BUSY_ADDR] <= 1'b1;
    end
  end

  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;
  assign RD_STALL = r_rd_stall;
  assign BUSY     = r_busy;
  assign ADDR_ERR = r_addr_err;

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: directed scenarios plus random traffic against an array-based reference model,
// and a NUM_REGS=3 instance for out-of-range index handling.
module tb_multiport_register_file;

  localparam int W = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, busy_set;
  logic [1:0]    wr_addr, busy_addr;
  logic [W-1:0]  wr_data;
  logic [1:0]    rd_en;
  logic [3:0]    rd_addr;
  logic [2*W-1:0] rd_data;
  logic [1:0]    rd_valid, rd_stall;
  logic [3:0]    busy;
  logic          addr_err;

  logic          wr_en3, busy_set3;
  logic [1:0]    wr_addr3, busy_addr3;
  logic [W-1:0]  wr_data3;
  logic [1:0]    rd_en3;
  logic [3:0]    rd_addr3;
  logic [2*W-1:0] rd_data3;
  logic [1:0]    rd_valid3, rd_stall3;
  logic [2:0]    busy3;
  logic          addr_err3;

  always #5 clk = ~clk;

  multiport_register_file #(.WORD_SIZE(W), .NUM_REGS(4), .NUM_RD_PORTS(2)) u_dut (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .BUSY_SET(busy_set), .BUSY_ADDR(busy_addr), .RD_EN(rd_en), .RD_ADDR(rd_addr),
    .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_STALL(rd_stall), .BUSY(busy), .ADDR_ERR(addr_err)
  );

  multiport_register_file #(.WORD_SIZE(W), .NUM_REGS(3), .NUM_RD_PORTS(2)) u_dut3 (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en3), .WR_ADDR(wr_addr3), .WR_DATA(wr_data3),
    .BUSY_SET(busy_set3), .BUSY_ADDR(busy_addr3), .RD_EN(rd_en3), .RD_ADDR(rd_addr3),
    .RD_DATA(rd_data3), .RD_VALID(rd_valid3), .RD_STALL(rd_stall3), .BUSY(busy3), .ADDR_ERR(addr_err3)
  );

  // Reference model state for the 4-register instance.
  logic [W-1:0] m_regs [4];
  logic [3:0]   m_busy;
  logic [W-1:0] m_data [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_busy = '0;
    m_data[0] = '0;
    m_data[1] = '0;
  endtask

  // Predict the next outputs from pre-edge state and inputs, clock once, then compare everything.
  task automatic tick();
    logic [W-1:0] e_data [2];
    logic [1:0]   e_valid, e_stall;
    logic [1:0]   a;
    e_valid = '0;
    e_stall = '0;
    for (int p = 0; p < 2; p++) begin
      e_data[p] = m_data[p];
      if (rd_en[p]) begin
        a = rd_addr[p*2 +: 2];
`ifdef WRITE_BYPASS_EN
        if (wr_en && wr_addr == a) begin
          e_valid[p] = 1'b1;
          e_data[p]  = wr_data;
        end else
`endif
        if (m_busy[a]) e_stall[p] = 1'b1;
        else begin
          e_valid[p] = 1'b1;
          e_data[p]  = m_regs[a];
        end
      end
    end
    if (wr_en) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (busy_set) m_busy[busy_addr] = 1'b1;
    @(posedge clk);
    #1;
    m_data[0] = e_data[0];
    m_data[1] = e_data[1];
    check("rd_valid", 64'(rd_valid), 64'(e_valid));
    check("rd_stall", 64'(rd_stall), 64'(e_stall));
    check("busy",     64'(busy),     64'(m_busy));
    check("addr_err", 64'(addr_err), 64'd0);
    for (int p = 0; p < 2; p++) check("rd_data", 64'(rd_data[p*W +: W]), 64'(e_data[p]));
  endtask

  task automatic idle();
    wr_en = 1'b0; busy_set = 1'b0; rd_en = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    idle();
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [1:0] en, input logic [1:0] a0, input logic [1:0] a1);
    idle();
    rd_en = en; rd_addr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; busy_set = 0; busy_addr = 0; rd_en = 0; rd_addr = 0;
    wr_en3 = 0; wr_addr3 = 0; wr_data3 = 0; busy_set3 = 0; busy_addr3 = 0; rd_en3 = 0; rd_addr3 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(rd_valid), 64'd0);
    check("reset_busy",  64'(busy),     64'd0);
    check("reset_data",  64'(rd_data),  64'd0);
    check("reset_err",   64'(addr_err), 64'd0);
    rst_n = 1'b1;

    // Write max value to r2, read on both ports.
    wr(2'd2, 19'h7FFFF); tick();
    rd(2'b11, 2'd2, 2'd2); tick();
    check("t2_valid", 64'(rd_valid), 64'h3);
    check("t2_p0", 64'(rd_data[0 +: W]), 64'h7FFFF);
    check("t2_p1", 64'(rd_data[W +: W]), 64'h7FFFF);

    // Busy stall, then write clears busy.
    idle(); busy_set = 1'b1; busy_addr = 2'd1; tick();
    rd(2'b01, 2'd1, 2'd0); tick();
    check("t3_stall", 64'(rd_stall[0]), 64'd1);
    check("t3_novalid", 64'(rd_valid[0]), 64'd0);
    wr(2'd1, 19'h00123); tick();
    check("t3_busy1", 64'(busy[1]), 64'd0);
    rd(2'b01, 2'd1, 2'd0); tick();
    check("t3_data", 64'(rd_data[0 +: W]), 64'h00123);

    // Same-cycle write and read of r3.
    wr(2'd3, 19'h0000A); tick();
    wr(2'd3, 19'h55555); rd_en = 2'b10; rd_addr = {2'd3, 2'd0}; tick();
`ifdef WRITE_BYPASS_EN
    check("t4_p1", 64'(rd_data[W +: W]), 64'h55555);
`else
    check("t4_p1", 64'(rd_data[W +: W]), 64'h0000A);
`endif

    // Busy set and write on the same index: set wins.
    wr(2'd0, 19'h00001); busy_set = 1'b1; busy_addr = 2'd0; tick();
    check("t5_busy0", 64'(busy[0]), 64'd1);
    wr(2'd0, 19'h00001); tick();
    rd(2'b01, 2'd0, 2'd0); tick();
    check("t5_r0", 64'(rd_data[0 +: W]), 64'h00001);

    // Out-of-range handling on the 3-register instance.
    idle();
    for (int i = 0; i < 3; i++) begin
      wr_en3 = 1'b1; wr_addr3 = 2'(i); wr_data3 = 19'(32'h11 * (i + 1));
      tick();
    end
    wr_en3 = 1'b1; wr_addr3 = 2'd3; wr_data3 = 19'h7FFFF; tick();
    check("t6_wr_err", 64'(addr_err3), 64'd1);
    wr_en3 = 1'b0; rd_en3 = 2'b11; rd_addr3 = {2'd1, 2'd0}; tick();
    check("t6_err_clr", 64'(addr_err3), 64'd0);
    check("t6_r0", 64'(rd_data3[0 +: W]), 64'h11);
    check("t6_r1", 64'(rd_data3[W +: W]), 64'h22);
    rd_addr3 = {2'd3, 2'd2}; tick();
    check("t6_r2", 64'(rd_data3[0 +: W]), 64'h33);
    check("t6_oor_valid", 64'(rd_valid3), 64'h3);
    check("t6_oor_data", 64'(rd_data3[W +: W]), 64'd0);
    check("t6_rd_err", 64'(addr_err3), 64'd1);
    busy_set3 = 1'b1; busy_addr3 = 2'd3; rd_en3 = 2'b00; tick();
    check("t6_bs_err", 64'(addr_err3), 64'd1);
    check("t6_busy3", 64'(busy3), 64'd0);
    busy_set3 = 1'b0; tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 19'($urandom);
      busy_set  = ($urandom_range(0, 3) == 0);
      busy_addr = 2'($urandom_range(0, 3));
      rd_en     = 2'($urandom_range(0, 3));
      rd_addr   = 4'($urandom_range(0, 15));
      tick();
    end

    // Reset asserted with reads in flight.
    wr(2'd2, 19'h2AAAA); tick();
    rd(2'b11, 2'd2, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", 64'(rd_valid), 64'd0);
    check("t1_busy",  64'(busy),     64'd0);
    check("t1_data",  64'(rd_data),  64'd0);
    @(posedge clk);
    #1;
    check("t1_dropped", 64'(rd_valid), 64'd0);
    idle();
    rst_n = 1'b1;
    model_reset();
    rd(2'b11, 2'd0, 2'd1); tick();
    check("t1_r01", 64'(rd_data), 64'd0);
    rd(2'b11, 2'd2, 2'd3); tick();
    check("t1_r23_valid", 64'(rd_valid), 64'h3);
    check("t1_r23", 64'(rd_data), 64'd0);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
